ps2_mouse_init_seq: RTL and testbench

//  Configures the PS/2 mouse through PS2_Controller's host-command interface: reset, sample rate,

---
 rtl/ps2_mouse_init_seq_pkg.sv | 44 ++++
 rtl/ps2_mouse_init_seq_if.sv | 38 +++
 rtl/ps2_mouse_init_seq_rom.sv | 32 +++
 rtl/ps2_mouse_init_seq.sv | 199 +++++++++++++++++++
 tb/tb_ps2_mouse_init_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_init_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_init_seq_pkg
//  Purpose  : PS/2 mouse command/response bytes, FSM states and ROM entry type
//  Revision : 1.0  initial release
// ============================================================================
package ps2_mouse_init_seq_pkg;

    // Host-to-mouse command bytes
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_SET_RES  = 8'hE8;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // Mouse-to-host response bytes
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] MOUSE_ID     = 8'h00;

    // Index of the final command (enable streaming) in the init list
    localparam logic [2:0] LAST_IDX     = 3'd5;

    typedef enum logic [3:0] {
        ST_POWERUP   = 4'd0,
        ST_SEND      = 4'd1,
        ST_WAIT_SENT = 4'd2,
        ST_WAIT_ACK  = 4'd3,
        ST_WAIT_BAT  = 4'd4,
        ST_WAIT_ID   = 4'd5,
        ST_NEXT      = 4'd6,
        ST_FAIL      = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERROR     = 4'd9
    } state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic       expects_bat_id;
    } rom_entry_t;

endpackage
`default_nettype wire

// File: rtl/ps2_mouse_init_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_init_seq_if
//  Purpose  : Host-command / receive bus between the init sequencer and the
//             PS/2 controller
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_mouse_init_seq_if;

    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent;
    logic       cmd_timed_out;
    logic [7:0] received_data;
    logic       received_data_en;

    // Sequencer side: issues commands, consumes status and received bytes
    modport master (
        output the_command,
        output send_command,
        input  command_was_sent,
        input  cmd_timed_out,
        input  received_data,
        input  received_data_en
    );

    // Controller side
    modport slave (
        input  the_command,
        input  send_command,
        output command_was_sent,
        output cmd_timed_out,
        output received_data,
        output received_data_en
    );

endinterface
`default_nettype wire

// File: rtl/ps2_mouse_init_seq_rom.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_init_seq_rom
//  Purpose  : Init command list lookup: idx -> {command byte, expects BAT+ID}
//  Revision : 1.0  initial release
// ============================================================================
module ps2_mouse_init_seq_rom
    import ps2_mouse_init_seq_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RATE = 8'd100,
    parameter logic [7:0] RESOLUTION  = 8'd2
) (
    input  logic [2:0] idx,
    output rom_entry_t entry
);

    // Only the reset command is followed by self-test and ID bytes
    always_comb begin
        entry = '{cmd: CMD_RESET, expects_bat_id: 1'b0};
        case (idx)
            3'd0:    entry = '{cmd: CMD_RESET,    expects_bat_id: 1'b1};
            3'd1:    entry = '{cmd: CMD_SET_RATE, expects_bat_id: 1'b0};
            3'd2:    entry = '{cmd: SAMPLE_RATE,  expects_bat_id: 1'b0};
            3'd3:    entry = '{cmd: CMD_SET_RES,  expects_bat_id: 1'b0};
            3'd4:    entry = '{cmd: RESOLUTION,   expects_bat_id: 1'b0};
            3'd5:    entry = '{cmd: CMD_ENABLE,   expects_bat_id: 1'b0};
            default: entry = '{cmd: CMD_RESET,    expects_bat_id: 1'b0};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_init_seq
//  Purpose  : Configures a PS/2 mouse (reset, rate, resolution, streaming),
//             checks every response, retries, and gates stream bytes until
//             the mouse is streaming
//  Revision : 1.0  initial release
// ============================================================================
module ps2_mouse_init_seq
    import ps2_mouse_init_seq_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 25_000_000,
    parameter int unsigned RESP_TIMEOUT   = 50_000_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
    parameter logic [7:0]  RESOLUTION     = 8'd2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 reinit,
    ps2_mouse_init_seq_if.master host,
    output logic [7:0]           stream_data,
    output logic                 stream_data_en,
    output logic                 init_done,
    output logic                 init_error,
    output logic [2:0]           retry_count
);

    localparam int unsigned TMAX = (POWERUP_CYCLES > RESP_TIMEOUT) ? POWERUP_CYCLES : RESP_TIMEOUT;
    localparam int          TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PWR_LOAD  = TW'(POWERUP_CYCLES - 1);
    localparam logic [TW-1:0] RESP_LOAD = TW'(RESP_TIMEOUT);
    localparam logic [2:0]    MAX_R     = 3'(MAX_RETRIES);

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic          aa_seen;     // last byte forwarded in DONE was AA
    rom_entry_t    entry;
    logic          expired;
    logic          rx_en;
    logic [7:0]    rx;

    ps2_mouse_init_seq_rom #(
        .SAMPLE_RATE (SAMPLE_RATE),
        .RESOLUTION  (RESOLUTION)
    ) u_rom (
        .idx   (idx),
        .entry (entry)
    );

    assign rx_en   = host.received_data_en;
    assign rx      = host.received_data;
    assign expired = (timer == '0);

    // Bytes reach the packet decoder only while streaming; the ID byte of a
    // hot-plug AA,00 pair is swallowed because it is not movement data
    assign stream_data    = rx;
    assign stream_data_en = rx_en && (state == ST_DONE) && !(aa_seen && (rx == MOUSE_ID));

    // Init sequencer: shared down-counter timer, command index and retry logic
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state             <= ST_POWERUP;
            timer             <= PWR_LOAD;
            idx               <= 3'd0;
            retry_count       <= 3'd0;
            init_done         <= 1'b0;
            init_error        <= 1'b0;
            aa_seen           <= 1'b0;
            host.the_command  <= 8'h00;
            host.send_command <= 1'b0;
        end else begin
            host.send_command <= 1'b0;
            if (reinit) begin
                state       <= ST_POWERUP;
                timer       <= PWR_LOAD;
                idx         <= 3'd0;
                retry_count <= 3'd0;
                init_done   <= 1'b0;
                init_error  <= 1'b0;
                aa_seen     <= 1'b0;
            end else begin
                case (state)
                    ST_POWERUP: begin
                        if (expired) begin
                            idx   <= 3'd0;
                            state <= ST_SEND;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    ST_SEND: begin
                        host.the_command  <= entry.cmd;
                        host.send_command <= 1'b1;
                        timer             <= RESP_LOAD;
                        state             <= ST_WAIT_SENT;
                    end
                    ST_WAIT_SENT: begin
                        if (host.command_was_sent) begin
                            timer <= RESP_LOAD;
                            state <= ST_WAIT_ACK;
                        end else if (host.cmd_timed_out || expired) begin
                            state <= ST_FAIL;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    ST_WAIT_ACK: begin
                        // A byte arriving on the expiry cycle still counts
                        if (rx_en) begin
                            if (rx == RSP_ACK) begin
                                timer <= RESP_LOAD;
                                state <= entry.expects_bat_id ? ST_WAIT_BAT : ST_NEXT;
                            end else if (rx == RSP_RESEND) begin
                                state <= ST_FAIL;
                            end else begin
                                state <= ST_FAIL;
                            end
                        end else if (expired) begin
                            state <= ST_FAIL;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    ST_WAIT_BAT: begin
                        if (rx_en) begin
                            if (rx == RSP_BAT_OK) begin
                                timer <= RESP_LOAD;
                                state <= ST_WAIT_ID;
                            end else if (rx == RSP_BAT_FAIL) begin
                                state <= ST_FAIL;
                            end else begin
                                state <= ST_FAIL;
                            end
                        end else if (expired) begin
                            state <= ST_FAIL;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    ST_WAIT_ID: begin
                        if (rx_en) begin
                            state <= (rx == MOUSE_ID) ? ST_NEXT : ST_FAIL;
                        end else if (expired) begin
                            state <= ST_FAIL;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    ST_NEXT: begin
                        if (idx == LAST_IDX) begin
                            init_done <= 1'b1;
                            aa_seen   <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_SEND;
                        end
                    end
                    ST_FAIL: begin
                        if (retry_count < MAX_R) begin
                            retry_count <= retry_count + 3'd1;
                            idx         <= 3'd0;
                            state       <= ST_SEND;
                        end else begin
                            init_error <= 1'b1;
                            state      <= ST_ERROR;
                        end
                    end
                    ST_DONE: begin
                        if (rx_en) begin
                            if (aa_seen && (rx == MOUSE_ID)) begin
                                // Mouse was re-plugged: it has just reported
                                // self-test pass and ID, so configure again
                                retry_count <= 3'd0;
                                idx         <= 3'd0;
                                init_done   <= 1'b0;
                                aa_seen     <= 1'b0;
                                state       <= ST_SEND;
                            end else begin
                                aa_seen <= (rx == RSP_BAT_OK);
                            end
                        end
                    end
                    ST_ERROR: begin
                        state <= ST_ERROR;
                    end
                    default: begin
                        state <= ST_POWERUP;
                        timer <= PWR_LOAD;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_init_seq
//  Purpose  : Self-checking bench with a behavioural mouse/controller model
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_mouse_init_seq;

    localparam int         PWR  = 20;
    localparam int         RTO  = 100;
    localparam int         MAXR = 2;
    localparam logic [7:0] SR   = 8'd100;
    localparam logic [7:0] RES  = 8'd2;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       reinit = 1'b0;
    logic [7:0] stream_data;
    logic       stream_data_en;
    logic       init_done;
    logic       init_error;
    logic [2:0] retry_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] cmd_list [6];
    bit         ok;
    logic [7:0] cmd;
    int         n;
    int         strobes;
    logic [7:0] b;
    bit         prev_aa;

    ps2_mouse_init_seq_if bus ();

    ps2_mouse_init_seq #(
        .POWERUP_CYCLES (PWR),
        .RESP_TIMEOUT   (RTO),
        .MAX_RETRIES    (MAXR),
        .SAMPLE_RATE    (SR),
        .RESOLUTION     (RES)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .reinit         (reinit),
        .host           (bus),
        .stream_data    (stream_data),
        .stream_data_en (stream_data_en),
        .init_done      (init_done),
        .init_error     (init_error),
        .retry_count    (retry_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for a command strobe; does not advance past the strobe cycle
    task automatic wait_send(output bit found, output logic [7:0] c, output int cycles);
        found  = 1'b0;
        c      = 8'h00;
        cycles = 0;
        while (!found && cycles < 400) begin
            if (bus.send_command === 1'b1) begin
                found = 1'b1;
                c     = bus.the_command;
            end else begin
                tick();
                cycles++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] val, input bit exp_fwd);
        bus.received_data    = val;
        bus.received_data_en = 1'b1;
        #1;
        check("stream_en", {31'd0, stream_data_en}, {31'd0, exp_fwd});
        if (exp_fwd) check("stream_data", {24'd0, stream_data}, {24'd0, val});
        tick();
        bus.received_data_en = 1'b0;
    endtask

    // Mouse + controller model for one command.
    // mode 0: normal replies, 1: resend (FE), 2: FA on the timeout-expiry cycle,
    // 3: transmitted but mouse silent, 4: controller reports transmit timeout
    task automatic serve(input logic [7:0] exp_cmd, input int mode, input string tag);
        bit         f;
        logic [7:0] c;
        int         cyc;
        logic [7:0] q [$];
        wait_send(f, c, cyc);
        check({tag, "_seen"}, {31'd0, f}, 32'd1);
        check({tag, "_cmd"}, {24'd0, c}, {24'd0, exp_cmd});
        tick();
        check("strobe_width", {31'd0, bus.send_command}, 32'd0);
        send_byte(8'($urandom), 1'b0);
        repeat ($urandom_range(0, 3)) tick();
        if (mode == 4) begin
            bus.cmd_timed_out = 1'b1;
            tick();
            bus.cmd_timed_out = 1'b0;
        end else begin
            bus.command_was_sent = 1'b1;
            tick();
            bus.command_was_sent = 1'b0;
            if (mode == 2) begin
                repeat (RTO) tick();
                send_byte(8'hFA, 1'b0);
            end else if (mode == 1) begin
                repeat ($urandom_range(0, 4)) tick();
                send_byte(8'hFE, 1'b0);
            end else if (mode == 0) begin
                q.push_back(8'hFA);
                if (exp_cmd == 8'hFF) begin
                    q.push_back(8'hAA);
                    q.push_back(8'h00);
                end
                foreach (q[j]) begin
                    repeat ($urandom_range(0, 4)) tick();
                    send_byte(q[j], 1'b0);
                end
            end
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 10 && init_done !== 1'b1; k++) tick();
        check("init_done", {31'd0, init_done}, 32'd1);
    endtask

    task automatic hot_plug();
        send_byte(8'hAA, 1'b1);
        repeat ($urandom_range(0, 3)) tick();
        send_byte(8'h00, 1'b0);
        check("hotplug_done_low", {31'd0, init_done}, 32'd0);
    endtask

    initial begin
        cmd_list = '{8'hFF, 8'hF3, SR, 8'hE8, RES, 8'hF4};
        bus.command_was_sent = 1'b0;
        bus.cmd_timed_out    = 1'b0;
        bus.received_data    = 8'h08;
        bus.received_data_en = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_send", {31'd0, bus.send_command}, 32'd0);
        check("rst_cmd", {24'd0, bus.the_command}, 32'd0);
        check("rst_done", {31'd0, init_done}, 32'd0);
        check("rst_err", {31'd0, init_error}, 32'd0);
        check("rst_retry", {29'd0, retry_count}, 32'd0);
        check("rst_stream_en", {31'd0, stream_data_en}, 32'd0);
        bus.received_data_en = 1'b0;
        resetn = 1'b1;

        // Power-up wait, then FF
        wait_send(ok, cmd, n);
        check("powerup_latency", n, PWR + 1);

        // Happy path
        for (int i = 0; i < 6; i++) serve(cmd_list[i], 0, "happy");
        wait_done();
        check("happy_retry", {29'd0, retry_count}, 32'd0);

        // Streaming: fixed bytes then random ones checked against the forwarding rule
        send_byte(8'h08, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hFB, 1'b1);
        prev_aa = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            if (b == 8'h00) b = 8'h01;
            if (i % 4 == 0) b = 8'hAA;
            repeat ($urandom_range(0, 2)) tick();
            send_byte(b, !(prev_aa && b == 8'h00));
            prev_aa = (b == 8'hAA);
        end
        check("stream_still_done", {31'd0, init_done}, 32'd1);

        // Hot-plug, then a NAK on F3 forces one restart
        hot_plug();
        serve(8'hFF, 0, "hp");
        serve(8'hF3, 1, "nak");
        wait_send(ok, cmd, n);
        check("nak_resend_ff", {24'd0, cmd}, 32'hFF);
        check("nak_retry", {29'd0, retry_count}, 32'd1);
        for (int i = 0; i < 6; i++) serve(cmd_list[i], 0, "retry_pass");
        wait_done();
        check("retry_kept", {29'd0, retry_count}, 32'd1);

        // Hot-plug clears retries; FA on the expiry cycle still advances
        hot_plug();
        serve(8'hFF, 0, "hp2");
        check("hp_retry_cleared", {29'd0, retry_count}, 32'd0);
        serve(8'hF3, 2, "edge");
        wait_send(ok, cmd, n);
        check("edge_next_cmd", {24'd0, cmd}, {24'd0, SR});
        check("edge_retry", {29'd0, retry_count}, 32'd0);
        for (int i = 2; i < 6; i++) serve(cmd_list[i], 0, "edge_pass");
        wait_done();

        // Silent mouse after reinit: MAXR+1 attempts, then error
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        check("reinit_done_low", {31'd0, init_done}, 32'd0);
        for (int a = 0; a <= MAXR; a++) begin
            wait_send(ok, cmd, n);
            check("silent_retry", {29'd0, retry_count}, a);
            serve(8'hFF, (a == 1) ? 4 : 3, "silent");
        end
        for (int k = 0; k < 3 * RTO && init_error !== 1'b1; k++) tick();
        check("silent_err", {31'd0, init_error}, 32'd1);
        check("silent_err_retry", {29'd0, retry_count}, MAXR);
        check("silent_err_done", {31'd0, init_done}, 32'd0);
        strobes = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.send_command === 1'b1) strobes++;
            tick();
        end
        check("error_quiet", strobes, 0);

        // Reinit leaves ERROR and restarts the power-up wait
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        check("reinit_err_clr", {31'd0, init_error}, 32'd0);
        check("reinit_retry_clr", {29'd0, retry_count}, 32'd0);
        wait_send(ok, cmd, n);
        check("reinit_latency", n, PWR + 1);
        check("reinit_cmd", {24'd0, cmd}, 32'hFF);

        // Asynchronous reset while waiting for the ACK
        serve(8'hFF, 3, "pre_rst");
        resetn = 1'b0;
        #1;
        check("arst_cmd", {24'd0, bus.the_command}, 32'd0);
        check("arst_send", {31'd0, bus.send_command}, 32'd0);
        check("arst_done", {31'd0, init_done}, 32'd0);
        check("arst_err", {31'd0, init_error}, 32'd0);
        check("arst_retry", {29'd0, retry_count}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
